// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - MIPS instruction-fetch stage: PC, IF/ID register, stall watchdog
//
// Optional feature macro: FETCH_PERF_CNT_EN (stall/flush performance counters).
//
// Ports:
//   Clk, Reset          rising-edge clock, asynchronous active-high reset
//   PCSrc               taken branch/jump, redirects PC to Branch_Target
//   Branch_Target[31:0] redirect address, low two bits forced to 00
//   PC_Write            1 = hold PC, 0 = advance
//   IF_ID_Signal[1:0]   0 load, 1 hold, 2/3 flush
//   IMem_Instruction    instruction-memory read data at IMem_Address
//   IMem_Address        current PC
//   IF_Instruction      IMem_Instruction passed through for the hazard unit
//   ID_Instruction      IF/ID instruction
//   ID_PCPlus4          IF/ID PC+4
//   ID_Valid            IF/ID holds a real instruction
//   Stall_Timeout       consecutive-stall watchdog flag
//   Stall_Count         hold-edge counter (0 when feature disabled)
//   Flush_Count         flush-edge counter (0 when feature disabled)

module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          MAX_STALL = 15
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        PCSrc,
  input  logic [31:0] Branch_Target,
  input  logic        PC_Write,
  input  logic [1:0]  IF_ID_Signal,
  input  logic [31:0] IMem_Instruction,
  output logic [31:0] IMem_Address,
  output logic [31:0] IF_Instruction,
  output logic [31:0] ID_Instruction,
  output logic [31:0] ID_PCPlus4,
  output logic        ID_Valid,
  output logic        Stall_Timeout,
  output logic [15:0] Stall_Count,
  output logic [15:0] Flush_Count
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } state_t;

  localparam logic [15:0] MAX_STALL_C = MAX_STALL[15:0];

  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        do_flush;
  logic        do_hold;
  state_t      state;
  state_t      state_nxt;
  logic [15:0] stall_cnt;
  logic [15:0] stall_cnt_nxt;
  logic        timeout_nxt;
  logic        unused_target_bits;

  // Word-aligned fetch: the low target bits carry no information.
  assign unused_target_bits = &Branch_Target[1:0];

  assign pc_plus4       = pc + 32'd4;
  assign IMem_Address   = pc;
  assign IF_Instruction = IMem_Instruction;

  // A redirect always kills the wrong-path instruction, even over a hold.
  assign do_flush = PCSrc | IF_ID_Signal[1];
  assign do_hold  = ~do_flush & IF_ID_Signal[0];

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      pc <= RESET_PC;
    end else if (PCSrc) begin
      pc <= {Branch_Target[31:2], 2'b00};
    end else if (!PC_Write) begin
      pc <= pc_plus4;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      ID_Instruction <= 32'h0;
      ID_PCPlus4     <= 32'h0;
      ID_Valid       <= 1'b0;
    end else if (do_flush) begin
      ID_Instruction <= 32'h0;
      ID_PCPlus4     <= 32'h0;
      ID_Valid       <= 1'b0;
    end else if (!do_hold) begin
      ID_Instruction <= IMem_Instruction;
      ID_PCPlus4     <= pc_plus4;
      ID_Valid       <= 1'b1;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state         <= RUN;
      stall_cnt     <= 16'd0;
      Stall_Timeout <= 1'b0;
    end else begin
      state         <= state_nxt;
      stall_cnt     <= stall_cnt_nxt;
      Stall_Timeout <= timeout_nxt;
    end
  end

  // The counter tracks hold edges; a fresh stall starts at 1 so the flag
  // rises right after the MAX_STALL-th consecutive hold edge.
  always_comb begin
    state_nxt     = RUN;
    stall_cnt_nxt = 16'd0;
    timeout_nxt   = 1'b0;
    if (do_flush) begin
      state_nxt = FLUSH;
    end else if (do_hold) begin
      state_nxt = STALL;
      if (state != STALL) begin
        stall_cnt_nxt = 16'd1;
      end else if (stall_cnt == MAX_STALL_C) begin
        stall_cnt_nxt = stall_cnt;
      end else begin
        stall_cnt_nxt = stall_cnt + 16'd1;
      end
      timeout_nxt = (stall_cnt_nxt == MAX_STALL_C);
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] stall_count_q;
  logic [15:0] flush_count_q;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      stall_count_q <= 16'd0;
      flush_count_q <= 16'd0;
    end else begin
      if (do_hold && stall_count_q != 16'hFFFF) begin
        stall_count_q <= stall_count_q + 16'd1;
      end
      if (do_flush && flush_count_q != 16'hFFFF) begin
        flush_count_q <= flush_count_q + 16'd1;
      end
    end
  end

  assign Stall_Count = stall_count_q;
  assign Flush_Count = flush_count_q;
`else
  assign Stall_Count = 16'd0;
  assign Flush_Count = 16'd0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - table-driven checks for fetch_stage

module tb_fetch_stage;

  logic        Clk;
  logic        Reset;
  logic        PCSrc;
  logic [31:0] Branch_Target;
  logic        PC_Write;
  logic [1:0]  IF_ID_Signal;
  logic [31:0] IMem_Instruction;
  logic [31:0] IMem_Address;
  logic [31:0] IF_Instruction;
  logic [31:0] ID_Instruction;
  logic [31:0] ID_PCPlus4;
  logic        ID_Valid;
  logic        Stall_Timeout;
  logic [15:0] Stall_Count;
  logic [15:0] Flush_Count;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        pcsrc;
    logic [31:0] target;
    logic        pw;
    logic [1:0]  ifid;
    logic [31:0] addr;
    logic [31:0] id_instr;
    logic [31:0] id_pc4;
    logic        valid;
    logic        to;
    logic [15:0] scnt;
    logic [15:0] fcnt;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [31:0] imem(input logic [31:0] a);
    return a ^ 32'hC0DE_5A00;
  endfunction

  assign IMem_Instruction = imem(IMem_Address);

  fetch_stage #(
    .RESET_PC (32'h0040_0000),
    .MAX_STALL(3)
  ) dut (
    .Clk             (Clk),
    .Reset           (Reset),
    .PCSrc           (PCSrc),
    .Branch_Target   (Branch_Target),
    .PC_Write        (PC_Write),
    .IF_ID_Signal    (IF_ID_Signal),
    .IMem_Instruction(IMem_Instruction),
    .IMem_Address    (IMem_Address),
    .IF_Instruction  (IF_Instruction),
    .ID_Instruction  (ID_Instruction),
    .ID_PCPlus4      (ID_PCPlus4),
    .ID_Valid        (ID_Valid),
    .Stall_Timeout   (Stall_Timeout),
    .Stall_Count     (Stall_Count),
    .Flush_Count     (Flush_Count)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic pcsrc, input logic [31:0] target, input logic pw,
                              input logic [1:0] ifid, input logic [31:0] addr,
                              input logic [31:0] id_instr, input logic [31:0] id_pc4,
                              input logic valid, input logic to,
                              input logic [15:0] scnt, input logic [15:0] fcnt);
    vec_t v;
    v.pcsrc = pcsrc; v.target = target; v.pw = pw; v.ifid = ifid;
    v.addr = addr; v.id_instr = id_instr; v.id_pc4 = id_pc4;
    v.valid = valid; v.to = to; v.scnt = scnt; v.fcnt = fcnt;
    return v;
  endfunction

  task automatic check_perf(input string tag, input logic [15:0] scnt, input logic [15:0] fcnt);
    logic [15:0] es;
    logic [15:0] ef;
`ifdef FETCH_PERF_CNT_EN
    es = scnt;
    ef = fcnt;
`else
    es = 16'd0;
    ef = 16'd0;
`endif
    check({tag, ".stall_count"}, {16'd0, Stall_Count}, {16'd0, es});
    check({tag, ".flush_count"}, {16'd0, Flush_Count}, {16'd0, ef});
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, ".addr"},    IMem_Address, 32'h0040_0000);
    check({tag, ".if_inst"}, IF_Instruction, imem(32'h0040_0000));
    check({tag, ".id_inst"}, ID_Instruction, 32'h0);
    check({tag, ".id_pc4"},  ID_PCPlus4, 32'h0);
    check({tag, ".valid"},   {31'd0, ID_Valid}, 32'd0);
    check({tag, ".timeout"}, {31'd0, Stall_Timeout}, 32'd0);
    check({tag, ".stall_count"}, {16'd0, Stall_Count}, 32'd0);
    check({tag, ".flush_count"}, {16'd0, Flush_Count}, 32'd0);
  endtask

  initial begin
    // pcsrc target pw ifid | addr id_instr id_pc4 valid to scnt fcnt
    vecs.push_back(mk(0, 32'h0, 0, 2'd0, 32'h0040_0004, imem(32'h0040_0000), 32'h0040_0004, 1, 0, 0, 0));
    vecs.push_back(mk(0, 32'h0, 0, 2'd0, 32'h0040_0008, imem(32'h0040_0004), 32'h0040_0008, 1, 0, 0, 0));
    vecs.push_back(mk(0, 32'h0, 0, 2'd0, 32'h0040_000C, imem(32'h0040_0008), 32'h0040_000C, 1, 0, 0, 0));
    vecs.push_back(mk(0, 32'h0, 1, 2'd1, 32'h0040_000C, imem(32'h0040_0008), 32'h0040_000C, 1, 0, 1, 0));
    vecs.push_back(mk(0, 32'h0, 1, 2'd1, 32'h0040_000C, imem(32'h0040_0008), 32'h0040_000C, 1, 0, 2, 0));
    vecs.push_back(mk(0, 32'h0, 0, 2'd0, 32'h0040_0010, imem(32'h0040_000C), 32'h0040_0010, 1, 0, 2, 0));
    vecs.push_back(mk(1, 32'h0000_1003, 0, 2'd0, 32'h0000_1000, 32'h0, 32'h0, 0, 0, 2, 1));
    vecs.push_back(mk(0, 32'h0, 0, 2'd0, 32'h0000_1004, imem(32'h0000_1000), 32'h0000_1004, 1, 0, 2, 1));
    vecs.push_back(mk(0, 32'h0, 1, 2'd1, 32'h0000_1004, imem(32'h0000_1000), 32'h0000_1004, 1, 0, 3, 1));
    vecs.push_back(mk(0, 32'h0, 1, 2'd1, 32'h0000_1004, imem(32'h0000_1000), 32'h0000_1004, 1, 0, 4, 1));
    vecs.push_back(mk(0, 32'h0, 1, 2'd1, 32'h0000_1004, imem(32'h0000_1000), 32'h0000_1004, 1, 1, 5, 1));
    vecs.push_back(mk(0, 32'h0, 1, 2'd1, 32'h0000_1004, imem(32'h0000_1000), 32'h0000_1004, 1, 1, 6, 1));
    vecs.push_back(mk(0, 32'h0, 1, 2'd1, 32'h0000_1004, imem(32'h0000_1000), 32'h0000_1004, 1, 1, 7, 1));
    vecs.push_back(mk(0, 32'h0, 0, 2'd0, 32'h0000_1008, imem(32'h0000_1004), 32'h0000_1008, 1, 0, 7, 1));
    vecs.push_back(mk(1, 32'hFFFF_FFFE, 0, 2'd1, 32'hFFFF_FFFC, 32'h0, 32'h0, 0, 0, 7, 2));
    vecs.push_back(mk(0, 32'h0, 0, 2'd0, 32'h0000_0000, imem(32'hFFFF_FFFC), 32'h0000_0000, 1, 0, 7, 2));
    vecs.push_back(mk(0, 32'h0, 0, 2'd2, 32'h0000_0004, 32'h0, 32'h0, 0, 0, 7, 3));
    vecs.push_back(mk(0, 32'h0, 1, 2'd3, 32'h0000_0004, 32'h0, 32'h0, 0, 0, 7, 4));
    vecs.push_back(mk(0, 32'h0, 1, 2'd0, 32'h0000_0004, imem(32'h0000_0004), 32'h0000_0008, 1, 0, 7, 4));
    vecs.push_back(mk(0, 32'h0, 0, 2'd0, 32'h0000_0008, imem(32'h0000_0004), 32'h0000_0008, 1, 0, 7, 4));

    Reset = 1'b1;
    PCSrc = 1'b0;
    Branch_Target = 32'h0;
    PC_Write = 1'b0;
    IF_ID_Signal = 2'd0;
    #2;
    check_reset_state("reset");
    @(negedge Clk);
    @(negedge Clk);
    Reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      string tag;
      tag = $sformatf("v%0d", i);
      PCSrc = vecs[i].pcsrc;
      Branch_Target = vecs[i].target;
      PC_Write = vecs[i].pw;
      IF_ID_Signal = vecs[i].ifid;
      @(posedge Clk);
      #1;
      check({tag, ".addr"},    IMem_Address, vecs[i].addr);
      check({tag, ".if_inst"}, IF_Instruction, imem(vecs[i].addr));
      check({tag, ".id_inst"}, ID_Instruction, vecs[i].id_instr);
      check({tag, ".id_pc4"},  ID_PCPlus4, vecs[i].id_pc4);
      check({tag, ".valid"},   {31'd0, ID_Valid}, {31'd0, vecs[i].valid});
      check({tag, ".timeout"}, {31'd0, Stall_Timeout}, {31'd0, vecs[i].to});
      check_perf(tag, vecs[i].scnt, vecs[i].fcnt);
      @(negedge Clk);
    end

    // Asynchronous reset in the middle of a stall with counters running.
    PCSrc = 1'b0;
    PC_Write = 1'b1;
    IF_ID_Signal = 2'd1;
    @(posedge Clk);
    @(posedge Clk);
    #1;
    check_perf("prestall", 16'd9, 16'd4);
    #2;
    Reset = 1'b1;
    #1;
    check_reset_state("async_reset");
    @(negedge Clk);
    Reset = 1'b0;
    PC_Write = 1'b0;
    IF_ID_Signal = 2'd0;
    @(posedge Clk);
    #1;
    check("post_reset.addr",   IMem_Address, 32'h0040_0004);
    check("post_reset.id_inst", ID_Instruction, imem(32'h0040_0000));
    check("post_reset.id_pc4", ID_PCPlus4, 32'h0040_0004);
    check("post_reset.valid",  {31'd0, ID_Valid}, 32'd1);
    check("post_reset.timeout", {31'd0, Stall_Timeout}, 32'd0);
    check_perf("post_reset", 16'd0, 16'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
